// File: rtl/fetch_queue_if.sv
// Fetch-to-dispatch handshake bundle for fetch_queue.
// The queue uses the slave modport; the fetch/dispatch/ROB side uses master.
interface fetch_queue_if #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned INSN_W = 32,
    parameter int unsigned PC_W   = 64
);
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

    logic              in_fetch_done;
    logic [INSN_W-1:0] in_fetch_insnbits;
    logic [PC_W-1:0]   in_fetch_pc;
    logic              out_fetch_stall;
    logic              in_rob_mispredict;
    logic              out_d_done;
    logic [INSN_W-1:0] out_d_insnbits;
    logic [PC_W-1:0]   out_d_pc;
    logic              in_d_ready;
    logic [CNT_W-1:0]  out_count;
    logic              out_overflow;

    modport master (
        output in_fetch_done, in_fetch_insnbits, in_fetch_pc, in_rob_mispredict, in_d_ready,
        input  out_fetch_stall, out_d_done, out_d_insnbits, out_d_pc, out_count, out_overflow
    );

    modport slave (
        input  in_fetch_done, in_fetch_insnbits, in_fetch_pc, in_rob_mispredict, in_d_ready,
        output out_fetch_stall, out_d_done, out_d_insnbits, out_d_pc, out_count, out_overflow
    );
endinterface

// File: rtl/fetch_queue.sv
// Circular instruction queue between fetch and dispatch, show-ahead head output.
// Optional macro FQ_BYPASS_EN: an empty queue forwards fetch straight to a ready dispatch.
module fetch_queue #(
    parameter int unsigned DEPTH  = 4,
    parameter int unsigned INSN_W = 32,
    parameter int unsigned PC_W   = 64
) (
    input  logic        in_clk,
    input  logic        in_rst,
    fetch_queue_if.slave fq
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
    localparam int unsigned ENT_W = INSN_W + PC_W;

    logic [ENT_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             overflow;

    logic             empty;
    logic             full;
    logic             push;
    logic             pop;
    logic             bypass;
    logic [ENT_W-1:0] head_entry;

    // Handshake qualification; stall derives from registered count only.
    always_comb begin
        empty      = (count == '0);
        full       = (count == CNT_W'(DEPTH));
`ifdef FQ_BYPASS_EN
        bypass     = in_rst & empty & fq.in_fetch_done & fq.in_d_ready & ~fq.in_rob_mispredict;
`else
        bypass     = 1'b0;
`endif
        push       = fq.in_fetch_done & ~full & ~fq.in_rob_mispredict & ~bypass;
        pop        = ~empty & fq.in_d_ready & ~fq.in_rob_mispredict;
        head_entry = mem[head];
    end

    // Dispatch-facing outputs are zero whenever nothing is presented.
    always_comb begin
        fq.out_fetch_stall = full;
        fq.out_count       = count;
        fq.out_overflow    = overflow;
        fq.out_d_done      = ~empty | bypass;
        fq.out_d_insnbits  = '0;
        fq.out_d_pc        = '0;
        if (!empty) begin
            fq.out_d_insnbits = head_entry[ENT_W-1:PC_W];
            fq.out_d_pc       = head_entry[PC_W-1:0];
        end
`ifdef FQ_BYPASS_EN
        else if (bypass) begin
            fq.out_d_insnbits = fq.in_fetch_insnbits;
            fq.out_d_pc       = fq.in_fetch_pc;
        end
`endif
    end

    // Storage is not reset; outputs are gated by occupancy instead.
    always_ff @(posedge in_clk) begin
        if (push) begin
            mem[tail] <= {fq.in_fetch_insnbits, fq.in_fetch_pc};
        end
    end

    always_ff @(posedge in_clk or negedge in_rst) begin
        if (!in_rst) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (fq.in_fetch_done && full) begin
                overflow <= 1'b1;
            end
            if (fq.in_rob_mispredict) begin
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (push) begin
                    tail <= tail + PTR_W'(1);
                end
                if (pop) begin
                    head <= head + PTR_W'(1);
                end
                if (push && !pop) begin
                    count <= count + CNT_W'(1);
                end else if (pop && !push) begin
                    count <= count - CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: doc/fetch_queue.md
FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 Parameter DEPTH, default 4, entry count (power of two, 2..16).
REQ-002 Parameter INSN_W, default 32 (`INSNBITS_SIZE).
REQ-003 Parameter PC_W, default 64 (`GPR_SIZE).
REQ-004 in_clk  input  1  clock; all state updates on rising edge.
REQ-005 in_rst  input  1  reset, asynchronous, active-low; one clock only, no other clock domains.
REQ-006 in_fetch_done  input  1  fetch presents a valid instruction this cycle.
REQ-007 in_fetch_insnbits  input  INSN_W  instruction bits from fetch.
REQ-008 in_fetch_pc  input  PC_W  PC of that instruction.
REQ-009 out_fetch_stall  output  1  queue full; fetch holds its current instruction.
REQ-010 in_rob_mispredict  input  1  flush request from ROB.
REQ-011 out_d_done  output  1  head entry valid toward dispatch.
REQ-012 out_d_insnbits  output  INSN_W  head instruction bits.
REQ-013 out_d_pc  output  PC_W  head PC.
REQ-014 in_d_ready  input  1  dispatch consumes head this cycle.
REQ-015 out_count  output  $clog2(DEPTH)+1  current occupancy.
REQ-016 out_overflow  output  1  sticky error: push attempted while full.

Function
REQ-017 Circular buffer of DEPTH entries {insnbits, pc}; head/tail pointers wrap modulo DEPTH; separate occupancy counter 0..DEPTH.
REQ-018 Push = in_fetch_done & !out_fetch_stall & !in_rob_mispredict; writes tail, tail+1.
REQ-019 Pop = out_d_done & in_d_ready & !in_rob_mispredict; head+1.
REQ-020 out_d_done = (count != 0); out_d_insnbits/out_d_pc driven combinationally from head entry (show-ahead); values undefined-safe 0 when empty.
REQ-021 out_fetch_stall = (count == DEPTH), from registered count only; a pop in the same cycle does not clear stall until next cycle.
REQ-022 Push and pop same cycle, 0<count<DEPTH: count unchanged, both pointers advance.
REQ-023 Push at empty: entry visible on out_d_done the next cycle (1-cycle latency) unless FQ_BYPASS_EN.
REQ-024 in_fetch_done while full: entry dropped, no state change except out_overflow set to 1 next cycle; stays 1 until reset.
REQ-025 in_rob_mispredict=1: next cycle head=tail=0, count=0, out_d_done=0; simultaneous push and pop ignored; out_overflow unaffected.
REQ-026 Instruction bits of zero (end-of-program marker) are queued and delivered like any other entry.
REQ-027 Entries delivered strictly in push order; no entry duplicated or reordered across pointer wrap.

Reset
REQ-028 in_rst low asynchronously forces head=0, tail=0, count=0, out_d_done=0, out_fetch_stall=0, out_count=0, out_overflow=0, out_d_insnbits=0, out_d_pc=0.
REQ-029 Reset asserted mid-operation discards all entries; first push after release accepted on first rising edge with in_rst high.
REQ-030 Storage array contents need not be reset; outputs gated to 0 when empty.

Configuration
REQ-031 Macro FQ_BYPASS_EN: when defined, push into an empty queue with in_d_ready=1 drives out_d_done=1, out_d_insnbits/out_d_pc = fetch inputs in the same cycle, entry not stored, count stays 0.
REQ-032 Bypass suppressed when in_rob_mispredict=1; with bypass but in_d_ready=0, entry is stored normally.
REQ-033 Without FQ_BYPASS_EN: no combinational path from fetch inputs to dispatch outputs; REQ-023 latency applies.

Verification
REQ-034 Reset, push insn 0x8B020020 pc 0x0 -> next cycle out_d_done=1, out_d_insnbits=0x8B020020, out_d_pc=0x0, out_count=1.
REQ-035 in_d_ready=0, push 4 entries (pc 0,4,8,12) -> out_fetch_stall=1, out_count=4; 5th push pc 16 -> dropped, out_overflow=1.
REQ-036 From full, pop with in_d_ready=1 for 6 cycles while pushing pc 16..36 -> dispatch sees pc 0,4,8,12,16,20 in order across wrap.
REQ-037 count=3, assert in_rob_mispredict with push and pop -> next cycle out_count=0, out_d_done=0; following push pc 0x40 delivered first.
REQ-038 FQ_BYPASS_EN defined, empty, push pc 0x100 with in_d_ready=1 -> same-cycle out_d_done=1, out_d_pc=0x100, out_count stays 0.
REQ-039 Assert in_rst low between clock edges with count=2 -> outputs zero immediately, before next edge.
